// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline stall controller: stall causes, per-stage control word and its decode.
// Counter defaults are consumed only when STALL_PERF_CNT_EN is defined.
package pipeline_stall_ctrl_pkg;

   localparam int STALL_TIMEOUT_DEFAULT = 1024;
   localparam int CNT_W_DEFAULT         = 32;
   localparam int NUM_PERF              = 4;

   typedef enum logic [2:0] {
      SC_NONE,
      SC_DMISS,
      SC_FLUSH,
      SC_LOADUSE,
      SC_IMISS
   } stall_cause_e;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_ex_en;
      logic ex_mem_en;
      logic mem_wb_en;
      logic if_id_bubble;
      logic id_ex_bubble;
      logic mem_wb_bubble;
   } stage_ctrl_t;

   localparam stage_ctrl_t CTRL_RUN     = stage_ctrl_t'(8'b11111_000);
   localparam stage_ctrl_t CTRL_DFRZ    = stage_ctrl_t'(8'b00001_001);
   localparam stage_ctrl_t CTRL_FLUSH   = stage_ctrl_t'(8'b11111_110);
   localparam stage_ctrl_t CTRL_LOADUSE = stage_ctrl_t'(8'b00111_010);
   localparam stage_ctrl_t CTRL_IFRZ    = stage_ctrl_t'(8'b01111_100);
   localparam stage_ctrl_t CTRL_RESET   = stage_ctrl_t'(8'b00000_111);

   function automatic stage_ctrl_t decode_cause(input stall_cause_e cause);
      stage_ctrl_t s;
      s = CTRL_RUN;
      case (cause)
         SC_DMISS:   s = CTRL_DFRZ;
         SC_FLUSH:   s = CTRL_FLUSH;
         SC_LOADUSE: s = CTRL_LOADUSE;
         SC_IMISS:   s = CTRL_IFRZ;
         default:    s = CTRL_RUN;
      endcase
      return s;
   endfunction

   // Flushes advance the pipeline, so only the three freeze causes feed the watchdog.
   function automatic logic is_stall(input stall_cause_e cause);
      return (cause == SC_DMISS) || (cause == SC_LOADUSE) || (cause == SC_IMISS);
   endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/miss events in, per-stage enables and bubble strobes out.
// Perf counter outputs exist only when STALL_PERF_CNT_EN is defined.
interface pipeline_stall_ctrl_if
   import pipeline_stall_ctrl_pkg::*;
`ifdef STALL_PERF_CNT_EN
   #(parameter int CNT_W = CNT_W_DEFAULT)
`endif
   ();

   logic load_use_stall;
   logic branch_taken;
   logic icache_miss;
   logic icache_ready;
   logic dcache_miss;
   logic dcache_ready;

   logic pc_en;
   logic if_id_en;
   logic id_ex_en;
   logic ex_mem_en;
   logic mem_wb_en;
   logic if_id_bubble;
   logic id_ex_bubble;
   logic mem_wb_bubble;
   logic stall_timeout;

`ifdef STALL_PERF_CNT_EN
   logic [CNT_W-1:0] perf_dstall;
   logic [CNT_W-1:0] perf_istall;
   logic [CNT_W-1:0] perf_lu_stall;
   logic [CNT_W-1:0] perf_flush;

   modport master (
      output load_use_stall, branch_taken, icache_miss, icache_ready, dcache_miss, dcache_ready,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
      input  if_id_bubble, id_ex_bubble, mem_wb_bubble, stall_timeout,
      input  perf_dstall, perf_istall, perf_lu_stall, perf_flush
   );
   modport slave (
      input  load_use_stall, branch_taken, icache_miss, icache_ready, dcache_miss, dcache_ready,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
      output if_id_bubble, id_ex_bubble, mem_wb_bubble, stall_timeout,
      output perf_dstall, perf_istall, perf_lu_stall, perf_flush
   );
`else
   modport master (
      output load_use_stall, branch_taken, icache_miss, icache_ready, dcache_miss, dcache_ready,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
      input  if_id_bubble, id_ex_bubble, mem_wb_bubble, stall_timeout
   );
   modport slave (
      input  load_use_stall, branch_taken, icache_miss, icache_ready, dcache_miss, dcache_ready,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
      output if_id_bubble, id_ex_bubble, mem_wb_bubble, stall_timeout
   );
`endif

endinterface

// File: rtl/pipeline_stall_ctrl_perf.sv
// Free-running wrap-around cycle counter for one stall cause.
// Compiled only when STALL_PERF_CNT_EN is defined.
`ifdef STALL_PERF_CNT_EN
module stall_perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (inc) begin
         count_reg <= count_reg + CNT_W'(1);
      end
   end

   assign count = count_reg;

endmodule
`endif

// File: rtl/pipeline_stall_ctrl.sv
// Resolves D$/I$ miss waits, branch flushes and load-use stalls into per-stage enables/bubbles
// with a sticky stall watchdog. Define STALL_PERF_CNT_EN to add per-cause cycle counters.
module pipeline_stall_ctrl
   import pipeline_stall_ctrl_pkg::*;
#(
   parameter int STALL_TIMEOUT = STALL_TIMEOUT_DEFAULT
`ifdef STALL_PERF_CNT_EN
   , parameter int CNT_W = CNT_W_DEFAULT
`endif
) (
   input logic                  clk,
   input logic                  rst_n,
   pipeline_stall_ctrl_if.slave bus
);

   localparam int SC_W = $clog2(STALL_TIMEOUT + 1);

   logic            d_wait_reg, d_wait_next;
   logic            i_wait_reg, i_wait_next;
   logic [SC_W-1:0] stall_cnt_reg, stall_cnt_next;
   logic            stall_timeout_reg, stall_timeout_next;
   logic            d_frz, i_frz;
   stall_cause_e    cause;
   stage_ctrl_t     ctrl;

   // A miss freezes in its pulse cycle; the ready cycle itself already runs.
   always_comb begin
      d_frz = bus.dcache_miss | (d_wait_reg & ~bus.dcache_ready);
      i_frz = bus.icache_miss | (i_wait_reg & ~bus.icache_ready);
      cause = SC_NONE;
      if (d_frz) begin
         cause = SC_DMISS;
      end else if (bus.branch_taken) begin
         cause = SC_FLUSH;
      end else if (bus.load_use_stall) begin
         cause = SC_LOADUSE;
      end else if (i_frz) begin
         cause = SC_IMISS;
      end
   end

   // A winning redirect abandons any outstanding fetch, so it drops i_wait as well.
   always_comb begin
      d_wait_next = bus.dcache_ready ? 1'b0 : (bus.dcache_miss | d_wait_reg);
      i_wait_next = (bus.icache_ready || (cause == SC_FLUSH)) ? 1'b0
                                                              : (bus.icache_miss | i_wait_reg);
      stall_cnt_next = '0;
      if (is_stall(cause)) begin
         if (stall_cnt_reg == SC_W'(STALL_TIMEOUT)) begin
            stall_cnt_next = stall_cnt_reg;
         end else begin
            stall_cnt_next = stall_cnt_reg + SC_W'(1);
         end
      end
      stall_timeout_next = stall_timeout_reg | (stall_cnt_next == SC_W'(STALL_TIMEOUT));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_wait_reg        <= 1'b0;
         i_wait_reg        <= 1'b0;
         stall_cnt_reg     <= '0;
         stall_timeout_reg <= 1'b0;
      end else begin
         d_wait_reg        <= d_wait_next;
         i_wait_reg        <= i_wait_next;
         stall_cnt_reg     <= stall_cnt_next;
         stall_timeout_reg <= stall_timeout_next;
      end
   end

   // Reset forces every stage into hold-and-bubble regardless of the inputs.
   always_comb begin
      ctrl = CTRL_RESET;
      if (rst_n) begin
         ctrl = decode_cause(cause);
      end
   end

   assign bus.pc_en         = ctrl.pc_en;
   assign bus.if_id_en      = ctrl.if_id_en;
   assign bus.id_ex_en      = ctrl.id_ex_en;
   assign bus.ex_mem_en     = ctrl.ex_mem_en;
   assign bus.mem_wb_en     = ctrl.mem_wb_en;
   assign bus.if_id_bubble  = ctrl.if_id_bubble;
   assign bus.id_ex_bubble  = ctrl.id_ex_bubble;
   assign bus.mem_wb_bubble = ctrl.mem_wb_bubble;
   assign bus.stall_timeout = stall_timeout_reg;

`ifdef STALL_PERF_CNT_EN
   logic [CNT_W-1:0] perf_cnt [NUM_PERF];

   // Counter gi tracks cause gi+1 (DMISS, FLUSH, LOADUSE, IMISS).
   for (genvar gi = 0; gi < NUM_PERF; gi++) begin : g_perf
      stall_perf_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .inc   (cause == stall_cause_e'(3'(gi + 1))),
         .count (perf_cnt[gi])
      );
   end

   assign bus.perf_dstall   = perf_cnt[0];
   assign bus.perf_flush    = perf_cnt[1];
   assign bus.perf_lu_stall = perf_cnt[2];
   assign bus.perf_istall   = perf_cnt[3];
`endif

endmodule
